sys1_snd_mailbox: RTL
=====================

// Module: sys1_snd_mailbox
// PURPOSE
//  Bus-responder peripheral that bridges the main Z80 and the sound Z80 wrappers.
//  Main CPU writes sound commands to an IO port; they are queued in a small FIFO.
//  Each queued command raises NMI to the sound CPU, which reads it at a memory address.
//  A periodic tick raises a maskable IRQ, held until the sound CPU's interrupt acknowledge.
// PARAMETERS
//  DEPTH      4       FIFO entries, power of two, 1..8
//  CMD_PORT   8'h14   main-side IO address (low byte) of command write port
//  LATCH_ADR  16'he000 sound-side memory address of command read (pop)
//  STAT_ADR   16'he001 sound-side memory address of status read
// PORTS
//  clk        in   1   system clock, sole clock
//  reset_n    in   1   asynchronous, active-low reset
//  m_adr      in   8   main CPU address low byte
//  m_data     in   8   main CPU data out
//  m_ix       in   1   main CPU IO request, active high
//  m_wr       in   1   main CPU write strobe, active high
//  s_adr      in   16  sound CPU address
//  s_mx       in   1   sound CPU memory request (refresh excluded), active high
//  s_rd       in   1   sound CPU read strobe, active high
//  s_intack   in   1   sound CPU IRQ acknowledge (vector 0x38 fetch)
//  s_nmiack   in   1   sound CPU NMI acknowledge (vector 0x66 fetch)
//  irq_tick   in   1   one-clk pulse from video timing, 4 per frame
//  s_dout     out  8   read data to sound CPU
//  s_dout_en  out  1   high while s_dout drives the sound data bus
//  s_intreq   out  1   IRQ request to sound CPU, active high
//  s_nmireq   out  1   NMI request to sound CPU, active high
// BEHAVIOUR
//  Reset: FIFO empty, all pointers/count 0, s_intreq=0, s_nmireq=0, s_dout=0,
//   s_dout_en=0, overflow=0, in_service=0; all strobe edge registers cleared.
//  Reset mid-transfer discards queued commands; no partial state survives.
//  Write: wsel = m_ix & m_wr & (m_adr==CMD_PORT); push on rising edge of wsel
//   (one push per strobe regardless of strobe length). Full: drop data, set overflow.
//  Reads: rsel_l = s_mx & s_rd & (s_adr==LATCH_ADR); rsel_s likewise for STAT_ADR.
//   s_dout_en = rsel_l|rsel_s (combinational). s_dout = FIFO head for latch;
//   {overflow, in_service, 2'b0, count[3:0]} for status.
//  Pop on falling edge of rsel_l (data stable for whole read cycle); pop clears
//   in_service. Latch read when empty: returns last popped byte, no pop, no flag.
//  Status read falling edge clears overflow (unless a drop occurs same cycle: stays 1).
//  Simultaneous push+pop: both happen, count unchanged; push while full+pop same
//   cycle is accepted (pop frees slot first). Pointers wrap modulo DEPTH.
//  NMI FSM: IDLE -> (count!=0) -> REQ (s_nmireq=1) -> rising s_nmiack -> SERV
//   (s_nmireq=0, in_service=1) -> pop -> IDLE; re-request next cycle if count!=0.
//  IRQ: irq_tick sets s_intreq; rising edge of s_intack clears it; tick and ack in
//   the same cycle leave s_intreq=1 (new request wins). Extra ticks while pending merge.
//  All state registered on clk; outputs other than s_dout/s_dout_en are registers.
// STRUCTURE
//  sys1_snd_pkg: CMD_PORT/LATCH_ADR/STAT_ADR defaults, NMI state enum, status bit
//   positions.
//  Sub-module sys1_cmd_fifo: DEPTH x 8 FIFO, push/pop/head/count/full/empty;
//   responder decode, edge detect, NMI FSM and IRQ latch stay in top.
// TESTING
//  Single cmd: write 8'h5A to port 0x14 -> s_nmireq=1 next clk; nmiack -> 0;
//   read E000 -> s_dout=5A, count 1->0 after strobe falls.
//  Long strobe: hold wsel 6 clks -> exactly one push, count=1.
//  Overflow: DEPTH=4, five writes 1..5 -> status=8'h84; pops return 1,2,3,4;
//   status read then reads 8'h00 (overflow cleared).
//  Push+pop same clk with count=4 -> accepted, count stays 4, order preserved.
//  IRQ: tick -> s_intreq=1; tick and intack same clk -> stays 1; lone intack -> 0.
//  Reset asserted with 3 queued and s_intreq=1 -> all outputs 0 immediately
//   (async); after release, latch read returns 8'h00, no NMI.

Source files
------------

// File: rtl/sys1_snd_pkg.sv
// Shared constants, NMI state encoding and status byte layout for the sound mailbox.
package sys1_snd_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADR_W  = 16;
  localparam int unsigned CNT_W  = 4;

  localparam logic [7:0]       CMD_PORT_DEF  = 8'h14;
  localparam logic [ADR_W-1:0] LATCH_ADR_DEF = 16'he000;
  localparam logic [ADR_W-1:0] STAT_ADR_DEF  = 16'he001;

  typedef enum logic [1:0] {
    NMI_IDLE = 2'd0,
    NMI_REQ  = 2'd1,
    NMI_SERV = 2'd2
  } nmi_state_e;

  // Status byte as seen by the sound CPU at STAT_ADR
  typedef struct packed {
    logic             overflow;
    logic             in_service;
    logic [1:0]       rsvd;
    logic [CNT_W-1:0] count;
  } snd_status_t;

endpackage

// File: rtl/sys1_cmd_fifo.sv
// DEPTH x 8 command FIFO; pop frees a slot before a same-cycle push is judged.
module sys1_cmd_fifo
  import sys1_snd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rd_data_c,
  output logic [CNT_W-1:0]  count,
  output logic              drop_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] last_q;
  logic              empty_c;
  logic              full_c;
  logic              pop_ok_c;
  logic              push_ok_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_c   = (count_q == '0);
  assign full_c    = (count_q == CNT_W'(DEPTH));
  assign pop_ok_c  = pop & ~empty_c;
  assign push_ok_c = push & (~full_c | pop_ok_c);
  assign drop_c    = push & ~push_ok_c;

  // Empty reads return the most recently popped byte
  assign rd_data_c = empty_c ? last_q : mem_q[rd_ptr_q];
  assign count     = count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (push_ok_c) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_ok_c) begin
        last_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_q + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);
    end
  end

endmodule

// File: rtl/sys1_snd_mailbox.sv
// Main-to-sound CPU command mailbox: queued commands raise NMI, periodic tick raises IRQ.
module sys1_snd_mailbox
  import sys1_snd_pkg::*;
#(
  parameter int unsigned      DEPTH     = 4,
  parameter logic [7:0]       CMD_PORT  = CMD_PORT_DEF,
  parameter logic [ADR_W-1:0] LATCH_ADR = LATCH_ADR_DEF,
  parameter logic [ADR_W-1:0] STAT_ADR  = STAT_ADR_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        m_adr,
  input  logic [DATA_W-1:0] m_data,
  input  logic              m_ix,
  input  logic              m_wr,
  input  logic [ADR_W-1:0]  s_adr,
  input  logic              s_mx,
  input  logic              s_rd,
  input  logic              s_intack,
  input  logic              s_nmiack,
  input  logic              irq_tick,
  output logic [DATA_W-1:0] s_dout,
  output logic              s_dout_en,
  output logic              s_intreq,
  output logic              s_nmireq
);

  nmi_state_e        state_q, state_d;
  logic              nmireq_d;
  logic              in_service_q, in_service_d;
  logic              overflow_q;
  logic              intreq_q;
  logic              wsel_q, rsel_l_q, rsel_s_q, nmiack_q, intack_q;

  logic              wsel_c, rsel_l_c, rsel_s_c;
  logic              push_c, pop_c, stat_fall_c, nmiack_rise_c, intack_rise_c;
  logic [DATA_W-1:0] fifo_rd_c;
  logic [CNT_W-1:0]  count;
  logic              drop_c;
  snd_status_t       status_c;

  // Bus decode and strobe edge detection
  assign wsel_c        = m_ix & m_wr & (m_adr == CMD_PORT);
  assign rsel_l_c      = s_mx & s_rd & (s_adr == LATCH_ADR);
  assign rsel_s_c      = s_mx & s_rd & (s_adr == STAT_ADR);
  assign push_c        = wsel_c & ~wsel_q;
  assign pop_c         = rsel_l_q & ~rsel_l_c & (count != '0);
  assign stat_fall_c   = rsel_s_q & ~rsel_s_c;
  assign nmiack_rise_c = s_nmiack & ~nmiack_q;
  assign intack_rise_c = s_intack & ~intack_q;

  sys1_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_c),
    .pop       (pop_c),
    .wdata     (m_data),
    .rd_data_c (fifo_rd_c),
    .count     (count),
    .drop_c    (drop_c)
  );

  always_comb begin
    status_c            = '0;
    status_c.overflow   = overflow_q;
    status_c.in_service = in_service_q;
    status_c.count      = count;
  end

  assign s_dout_en = rsel_l_c | rsel_s_c;
  assign s_dout    = rsel_l_c ? fifo_rd_c
                   : rsel_s_c ? DATA_W'(status_c)
                   : '0;
  assign s_intreq  = intreq_q;

  // NMI handshake: request while work is queued, serviced until the next pop
  always_comb begin
    state_d      = state_q;
    nmireq_d     = 1'b0;
    in_service_d = 1'b0;
    unique case (state_q)
      NMI_IDLE: if (count != '0)   state_d = NMI_REQ;
      NMI_REQ:  if (nmiack_rise_c) state_d = NMI_SERV;
      NMI_SERV: if (pop_c)         state_d = NMI_IDLE;
      default:                     state_d = NMI_IDLE;
    endcase
    nmireq_d     = (state_d == NMI_REQ);
    in_service_d = (state_d == NMI_SERV);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= NMI_IDLE;
      s_nmireq     <= 1'b0;
      in_service_q <= 1'b0;
      overflow_q   <= 1'b0;
      intreq_q     <= 1'b0;
      wsel_q       <= 1'b0;
      rsel_l_q     <= 1'b0;
      rsel_s_q     <= 1'b0;
      nmiack_q     <= 1'b0;
      intack_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_nmireq     <= nmireq_d;
      in_service_q <= in_service_d;
      wsel_q       <= wsel_c;
      rsel_l_q     <= rsel_l_c;
      rsel_s_q     <= rsel_s_c;
      nmiack_q     <= s_nmiack;
      intack_q     <= s_intack;
      // A drop in the same cycle as a status read keeps the flag set
      if (drop_c)           overflow_q <= 1'b1;
      else if (stat_fall_c) overflow_q <= 1'b0;
      if (irq_tick)           intreq_q <= 1'b1;
      else if (intack_rise_c) intreq_q <= 1'b0;
    end
  end

endmodule
